// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// State numbering is visible on state_o for debug, so it is fixed explicitly.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_t;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b100;
  localparam logic [2:0] AluLsr = 3'b101;
  localparam logic [2:0] AluMov = 3'b110;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdEor = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdMov = 4'b1101;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluDirect = 2'b10;

  localparam logic [1:0] SrcbReg  = 2'b00;
  localparam logic [1:0] SrcbImm  = 2'b01;
  localparam logic [1:0] SrcbFour = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Data-processing decode: Funct -> ALU operation, NoWrite, arithmetic flag and legality.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          EXT_OPS   = 1'b1
) (
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 no_write,
  output logic                 arith,
  output logic                 legal
);

  logic [2:0] op;

  always_comb begin
    op       = AluAdd;
    no_write = 1'b0;
    arith    = 1'b0;
    legal    = 1'b1;
    case (funct[4:1])
      CmdAdd: arith = 1'b1;
      CmdSub: begin
        op    = AluSub;
        arith = 1'b1;
      end
      // CMP without S would discard its only result
      CmdCmp: begin
        op       = AluSub;
        arith    = 1'b1;
        no_write = 1'b1;
        legal    = EXT_OPS && funct[0];
      end
      CmdAnd: op = AluAnd;
      CmdOrr: op = AluOrr;
      CmdEor: begin
        op    = AluEor;
        legal = EXT_OPS;
      end
      CmdMov: begin
        op    = funct[5] ? AluMov : AluLsr;
        legal = EXT_OPS;
      end
      default: legal = 1'b0;
    endcase
  end

  assign alu_control = ALUCTRL_W'(op);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences each instruction over 3-5 cycles through a shared
// memory port and ALU. Outputs are decoded from the state register (no output registers).
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          EXT_OPS   = 1'b1,
  parameter bit          MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 CondEx,
  input  logic                 mem_ready,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic                 PCWrite,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 NoWrite,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  state_t state_q, state_d;
  logic   cond_q;
  logic   ready;

  logic [ALUCTRL_W-1:0] dec_alu;
  logic                 dec_no_write;
  logic                 dec_arith;
  logic                 dec_legal;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  mc_alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W),
    .EXT_OPS   (EXT_OPS)
  ) u_alu_decoder (
    .funct       (Funct),
    .alu_control (dec_alu),
    .no_write    (dec_no_write),
    .arith       (dec_arith),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) cond_q <= CondEx;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          2'b00:   state_d = !dec_legal ? StFetch : (Funct[5] ? StExecI : StExecR);
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:  if (ready) state_d = StMemWb;
      StMemWr:  if (ready) state_d = StFetch;
      StExecR,
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcbReg;
    ResultSrc  = ResAluOut;
    ALUControl = ALUCTRL_W'(AluAdd);
    FlagW      = 2'b00;
    PCWrite    = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    illegal    = 1'b0;
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
    NoWrite    = (Op == 2'b00) && dec_no_write;

    case (state_q)
      StFetch: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcbFour;
        ResultSrc = ResAluDirect;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcbFour;
        ResultSrc = ResAluDirect;
        illegal   = (Op == 2'b11) || ((Op == 2'b00) && !dec_legal);
      end
      StMemAdr: ALUSrcB = SrcbImm;
      StMemRd:  AdrSrc  = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        RegW      = cond_q;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        MemW   = cond_q && ready;
      end
      StExecR,
      StExecI: begin
        ALUSrcB    = (state_q == StExecI) ? SrcbImm : SrcbReg;
        ALUControl = dec_alu;
        FlagW      = {Funct[0], Funct[0] && dec_arith} & {2{cond_q}};
      end
      StAluWb:  RegW = cond_q && !NoWrite;
      StBranch: begin
        ALUSrcB   = SrcbImm;
        ResultSrc = ResAluDirect;
        PCWrite   = cond_q;
      end
      default: ;
    endcase

    // A register write to R15 is a jump
    if (RegW && (Rd == 4'hf)) PCWrite = 1'b1;

    if (reset) begin
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      FlagW   = 2'b00;
      illegal = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes cycle by cycle and checks
// state and write enables against hand-computed values.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       mem_ready;
  logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegW, MemW, NoWrite, illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .ALUCTRL_W (3),
    .EXT_OPS   (1'b1),
    .MEM_WAIT  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .CondEx     (CondEx),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .PCWrite    (PCWrite),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks one cycle at the falling edge, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input state_t st, input logic irw, input logic pcw,
                     input logic regw, input logic memw, input logic [1:0] fw,
                     input logic ill);
    @(negedge clk);
    check({tag, ".state"},   state_o, st);
    check({tag, ".irwrite"}, IRWrite, irw);
    check({tag, ".pcwrite"}, PCWrite, pcw);
    check({tag, ".regw"},    RegW,    regw);
    check({tag, ".memw"},    MemW,    memw);
    check({tag, ".flagw"},   FlagW,   fw);
    check({tag, ".illegal"}, illegal, ill);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input logic cond);
    Op     = op;
    Funct  = funct;
    Rd     = rd;
    CondEx = cond;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    set_instr(2'b00, 6'b000000, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    // FETCH with mem_ready=1 would write IR/PC if not for reset
    cyc("reset", StFetch, 0, 0, 0, 0, 2'b00, 0);
    reset = 1'b0;

    mem_ready = 1'b0;
    cyc("fstall0", StFetch, 0, 0, 0, 0, 2'b00, 0);
    cyc("fstall1", StFetch, 0, 0, 0, 0, 2'b00, 0);
    mem_ready = 1'b1;

    // ADD R1,R2,R3
    set_instr(2'b00, 6'b001000, 4'd1, 1'b1);
    cyc("add.fetch", StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("add.dec",   StDecode, 0, 0, 0, 0, 2'b00, 0);
    check("add.aluctl", ALUControl, 3'b000);
    check("add.srcb",   ALUSrcB,    2'b00);
    cyc("add.exec",  StExecR,  0, 0, 0, 0, 2'b00, 0);
    check("add.ressrc", ResultSrc, 2'b00);
    cyc("add.wb",    StAluWb,  0, 0, 1, 0, 2'b00, 0);

    // CMP: flags both written, no register write
    set_instr(2'b00, 6'b010101, 4'd0, 1'b1);
    cyc("cmp.fetch", StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("cmp.dec",   StDecode, 0, 0, 0, 0, 2'b00, 0);
    check("cmp.aluctl",  ALUControl, 3'b001);
    check("cmp.nowrite", NoWrite,    1'b1);
    cyc("cmp.exec",  StExecR,  0, 0, 0, 0, 2'b11, 0);
    cyc("cmp.wb",    StAluWb,  0, 0, 0, 0, 2'b00, 0);

    // ORRS immediate: logical op, NZ only
    set_instr(2'b00, 6'b111001, 4'd4, 1'b1);
    cyc("orrs.fetch", StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("orrs.dec",   StDecode, 0, 0, 0, 0, 2'b00, 0);
    check("orrs.aluctl", ALUControl, 3'b011);
    check("orrs.srcb",   ALUSrcB,    2'b01);
    cyc("orrs.exec",  StExecI,  0, 0, 0, 0, 2'b10, 0);
    cyc("orrs.wb",    StAluWb,  0, 0, 1, 0, 2'b00, 0);

    // ADD immediate into R15 jumps
    set_instr(2'b00, 6'b101000, 4'd15, 1'b1);
    cyc("addpc.fetch", StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("addpc.dec",   StDecode, 0, 0, 0, 0, 2'b00, 0);
    cyc("addpc.exec",  StExecI,  0, 0, 0, 0, 2'b00, 0);
    cyc("addpc.wb",    StAluWb,  0, 1, 1, 0, 2'b00, 0);

    // LDR with two wait cycles in MEMRD: 7 cycles total
    set_instr(2'b01, 6'b011001, 4'd2, 1'b1);
    cyc("ldr.fetch",  StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("ldr.dec",    StDecode, 0, 0, 0, 0, 2'b00, 0);
    check("ldr.srcb", ALUSrcB, 2'b01);
    cyc("ldr.memadr", StMemAdr, 0, 0, 0, 0, 2'b00, 0);
    mem_ready = 1'b0;
    check("ldr.adrsrc", AdrSrc, 1'b1);
    cyc("ldr.memrd0", StMemRd,  0, 0, 0, 0, 2'b00, 0);
    cyc("ldr.memrd1", StMemRd,  0, 0, 0, 0, 2'b00, 0);
    mem_ready = 1'b1;
    cyc("ldr.memrd2", StMemRd,  0, 0, 0, 0, 2'b00, 0);
    check("ldr.ressrc", ResultSrc, 2'b01);
    cyc("ldr.memwb",  StMemWb,  0, 0, 1, 0, 2'b00, 0);

    // STR with one wait cycle: MemW only in the ready cycle
    set_instr(2'b01, 6'b011000, 4'd3, 1'b1);
    cyc("str.fetch",  StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("str.dec",    StDecode, 0, 0, 0, 0, 2'b00, 0);
    cyc("str.memadr", StMemAdr, 0, 0, 0, 0, 2'b00, 0);
    mem_ready = 1'b0;
    cyc("str.memwr0", StMemWr,  0, 0, 0, 0, 2'b00, 0);
    mem_ready = 1'b1;
    cyc("str.memwr1", StMemWr,  0, 0, 0, 1, 2'b00, 0);

    // Branch not taken
    set_instr(2'b10, 6'b000000, 4'd0, 1'b0);
    cyc("b.fetch",  StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("b.dec",    StDecode, 0, 0, 0, 0, 2'b00, 0);
    cyc("b.branch", StBranch, 0, 0, 0, 0, 2'b00, 0);

    // Illegal: Op=11
    set_instr(2'b11, 6'b000000, 4'd0, 1'b1);
    cyc("op11.fetch", StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("op11.dec",   StDecode, 0, 0, 0, 0, 2'b00, 1);

    // Illegal DP cmd 0111
    set_instr(2'b00, 6'b001110, 4'd0, 1'b1);
    cyc("cmd7.fetch", StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("cmd7.dec",   StDecode, 0, 0, 0, 0, 2'b00, 1);

    // STR abandoned by reset in MEMWR
    set_instr(2'b01, 6'b011000, 4'd3, 1'b1);
    cyc("strrst.fetch",  StFetch,  1, 1, 0, 0, 2'b00, 0);
    cyc("strrst.dec",    StDecode, 0, 0, 0, 0, 2'b00, 0);
    cyc("strrst.memadr", StMemAdr, 0, 0, 0, 0, 2'b00, 0);
    reset = 1'b1;
    cyc("strrst.memwr",  StMemWr,  0, 0, 0, 0, 2'b00, 0);
    reset = 1'b0;
    cyc("strrst.after",  StFetch,  1, 1, 0, 0, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
